wb_arbiter: RTL and testbench

Parametrised N-master to 1-slave Wishbone (classic, single-transfer) arbiter that lets the instruction and data buses from `cpu`, plus later cache and L2 ports, share one memory Wishbone port. It supports fixed-priority or round-robin selection and holds a grant until the transfer terminates. A watchdog converts a stalled slave into a retry (`RTY`) to the owning master. It sits between the CPU/cache masters and physical memory in the top-level PC wrapper.

---
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// N-master to 1-slave classic Wishbone arbiter: fixed-priority or round-robin
// selection, grant held until the transfer terminates, watchdog converts a stalled slave into RTY.
module wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_W       = 27,
    parameter int DAT_W       = 256,
    parameter int SEL_W       = 32,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_MASTERS-1:0]       m_cyc,
    input  logic [NUM_MASTERS-1:0]       m_stb,
    input  logic [NUM_MASTERS-1:0]       m_we,
    input  logic [NUM_MASTERS*ADR_W-1:0] m_adr,
    input  logic [NUM_MASTERS*DAT_W-1:0] m_dat_w,
    input  logic [NUM_MASTERS*SEL_W-1:0] m_sel,
    output logic [DAT_W-1:0]             m_dat_r,
    output logic [NUM_MASTERS-1:0]       m_ack,
    output logic [NUM_MASTERS-1:0]       m_rty,
    output logic                         s_cyc,
    output logic                         s_stb,
    output logic                         s_we,
    output logic [ADR_W-1:0]             s_adr,
    output logic [DAT_W-1:0]             s_dat_w,
    output logic [SEL_W-1:0]             s_sel,
    input  logic [DAT_W-1:0]             s_dat_r,
    input  logic                         s_ack,
    input  logic                         s_rty,
    output logic [NUM_MASTERS-1:0]       grant,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [NUM_MASTERS-1:0] grant_nxt_s;
    logic [NUM_MASTERS-1:0] req_s;
    logic [IDX_W-1:0]       owner_r;
    logic [IDX_W-1:0]       last_owner_r;
    logic [IDX_W-1:0]       win_idx_s;
    logic [IDX_W-1:0]       cand_s;
    logic                   win_vld_s;
    logic [CNT_W-1:0]       wd_cnt_r;
    logic                   busy_s;
    logic                   own_cyc_s;
    logic                   term_s;
    logic                   abort_s;
    logic                   wd_fire_s;

    assign req_s     = m_cyc & m_stb;
    assign busy_s    = (state_r == BUSY);
    assign own_cyc_s = m_cyc[owner_r];
    assign term_s    = busy_s & (s_ack | s_rty);
    assign abort_s   = busy_s & ~term_s & ~own_cyc_s;
    // Expiry lands in the TIMEOUT-th BUSY cycle: the counter holds BUSY cycles already elapsed.
    assign wd_fire_s = busy_s & (TIMEOUT != 0) & ~term_s & own_cyc_s
                     & (wd_cnt_r == CNT_W'(TIMEOUT - 1));

    // Winner selection: scan candidates in priority order, first requester wins.
    always_comb begin
        win_idx_s = '0;
        win_vld_s = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand_s    = (RR_MODE != 0) ? IDX_W'((int'(last_owner_r) + 1 + k) % NUM_MASTERS)
                                       : IDX_W'(k);
            win_idx_s = (req_s[cand_s] && !win_vld_s) ? cand_s : win_idx_s;
            win_vld_s = win_vld_s | req_s[cand_s];
        end
    end

    // Next-state, next-grant and slave/master-side forwarding.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        s_cyc       = busy_s & own_cyc_s & ~wd_fire_s;
        s_stb       = busy_s & m_stb[owner_r] & ~wd_fire_s;
        s_we        = 1'b0;
        s_adr       = '0;
        s_dat_w     = '0;
        s_sel       = '0;
        m_ack       = '0;
        m_rty       = '0;
        m_dat_r     = s_dat_r;
        timeout_err = wd_fire_s;
        grant       = grant_r;
        case (state_r)
            IDLE: begin
                if (win_vld_s) begin
                    state_nxt_s          = BUSY;
                    grant_nxt_s          = '0;
                    grant_nxt_s[win_idx_s] = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                s_we           = m_we[owner_r];
                s_adr          = m_adr[int'(owner_r)*ADR_W +: ADR_W];
                s_dat_w        = m_dat_w[int'(owner_r)*DAT_W +: DAT_W];
                s_sel          = m_sel[int'(owner_r)*SEL_W +: SEL_W];
                m_ack[owner_r] = s_ack;
                m_rty[owner_r] = (s_rty & ~s_ack) | wd_fire_s;
                if (term_s || abort_s || wd_fire_s) begin
                    state_nxt_s = RELEASE;
                    grant_nxt_s = '0;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RELEASE: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
        endcase
    end

    // State, grant, owner tracking and watchdog counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            owner_r      <= '0;
            last_owner_r <= IDX_W'(NUM_MASTERS - 1);
            wd_cnt_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            if (state_r == IDLE && win_vld_s) begin
                owner_r <= win_idx_s;
            end
            if (term_s) begin
                last_owner_r <= owner_r;
            end
            if (state_r != BUSY) begin
                wd_cnt_r <= '0;
            end else if (wd_cnt_r != CNT_W'(TIMEOUT)) begin
                wd_cnt_r <= wd_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized transaction-level bench for wb_arbiter: one fixed-priority and one
// round-robin instance, expected winners and terminate timing from a small reference model.
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            rr_sel;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   s_dat_r;
    logic            s_ack, s_rty;

    logic [N-1:0]  fx_cyc_in, rr_cyc_in;
    logic          fx_ack_in, fx_rty_in, rr_ack_in, rr_rty_in;
    assign fx_cyc_in = m_cyc & {N{~rr_sel}};
    assign rr_cyc_in = m_cyc & {N{rr_sel}};
    assign fx_ack_in = s_ack & ~rr_sel;
    assign fx_rty_in = s_rty & ~rr_sel;
    assign rr_ack_in = s_ack & rr_sel;
    assign rr_rty_in = s_rty & rr_sel;

    logic [DW-1:0] fx_dat_r, rr_dat_r, fx_dat_w, rr_dat_w;
    logic [N-1:0]  fx_ack, fx_rty, fx_grant, rr_ack, rr_rty, rr_grant;
    logic          fx_cyc, fx_stb, fx_we, fx_to, rr_cyc, rr_stb, rr_we, rr_to;
    logic [AW-1:0] fx_adr, rr_adr;
    logic [SW-1:0] fx_sel, rr_sel_o;

    wb_arbiter #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .SEL_W(SW), .RR_MODE(0), .TIMEOUT(TO)) u_fx (
        .CLK(clk), .RST(rst), .m_cyc(fx_cyc_in), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(fx_dat_r), .m_ack(fx_ack), .m_rty(fx_rty),
        .s_cyc(fx_cyc), .s_stb(fx_stb), .s_we(fx_we), .s_adr(fx_adr), .s_dat_w(fx_dat_w),
        .s_sel(fx_sel), .s_dat_r(s_dat_r), .s_ack(fx_ack_in), .s_rty(fx_rty_in),
        .grant(fx_grant), .timeout_err(fx_to));

    wb_arbiter #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .SEL_W(SW), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
        .CLK(clk), .RST(rst), .m_cyc(rr_cyc_in), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(rr_dat_r), .m_ack(rr_ack), .m_rty(rr_rty),
        .s_cyc(rr_cyc), .s_stb(rr_stb), .s_we(rr_we), .s_adr(rr_adr), .s_dat_w(rr_dat_w),
        .s_sel(rr_sel_o), .s_dat_r(s_dat_r), .s_ack(rr_ack_in), .s_rty(rr_rty_in),
        .grant(rr_grant), .timeout_err(rr_to));

    // Outputs of whichever instance is under test.
    logic [N-1:0]  o_grant, o_ack, o_rty;
    logic          o_cyc, o_stb, o_we, o_to;
    logic [AW-1:0] o_adr;
    logic [DW-1:0] o_dat_w, o_dat_r;
    logic [SW-1:0] o_sel;
    assign o_grant = rr_sel ? rr_grant : fx_grant;
    assign o_ack   = rr_sel ? rr_ack   : fx_ack;
    assign o_rty   = rr_sel ? rr_rty   : fx_rty;
    assign o_cyc   = rr_sel ? rr_cyc   : fx_cyc;
    assign o_stb   = rr_sel ? rr_stb   : fx_stb;
    assign o_we    = rr_sel ? rr_we    : fx_we;
    assign o_to    = rr_sel ? rr_to    : fx_to;
    assign o_adr   = rr_sel ? rr_adr   : fx_adr;
    assign o_dat_w = rr_sel ? rr_dat_w : fx_dat_w;
    assign o_dat_r = rr_sel ? rr_dat_r : fx_dat_r;
    assign o_sel   = rr_sel ? rr_sel_o : fx_sel;

    int n_vec = 0;
    int n_err = 0;
    int last_m [2];

    // Reference arbitration rule: fixed = lowest index, rr = first index after the last owner.
    function automatic int pick(input bit rr, input logic [N-1:0] req, input int last);
        int start;
        start = rr ? (last + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_rty = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rr_sel = 1'b0; idle_inputs();
        m_adr = '0; m_dat_w = '0; m_sel = '0; s_dat_r = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_m[0] = N - 1; last_m[1] = N - 1;
        @(negedge clk);
        n_vec++;
        if ({fx_grant, fx_cyc, fx_stb, fx_we, fx_adr, fx_dat_w, fx_sel, fx_ack, fx_rty, fx_to,
             rr_grant, rr_cyc, rr_stb, rr_we, rr_adr, rr_dat_w, rr_sel_o, rr_ack, rr_rty, rr_to} !== '0) begin
            n_err++;
            $display("FAIL reset_state: fx grant=%b cyc=%b adr=%h rr grant=%b cyc=%b adr=%h, required all zero",
                     fx_grant, fx_cyc, fx_adr, rr_grant, rr_cyc, rr_adr);
        end
        @(posedge clk); #1;
    endtask

    // One transfer. term: 0 ack, 1 rty, 2 ack+rty, 3 silent slave, 4 owner abort.
    // Terminate happens in BUSY cycle dly+1 unless the watchdog gets there first.
    task automatic txn(input bit rr, input logic [N-1:0] req, input int dly, input int term);
        int w, end_c;
        bit wd, exp_cyc, exp_to;
        logic [N-1:0] oh, exp_ack, exp_rty;
        rr_sel = rr;
        for (int i = 0; i < N; i++) begin
            m_adr[i*AW +: AW]   = AW'($urandom);
            m_dat_w[i*DW +: DW] = DW'($urandom);
            m_sel[i*SW +: SW]   = SW'($urandom);
        end
        m_we = N'($urandom); m_cyc = req; m_stb = req; s_ack = 1'b0; s_rty = 1'b0;
        w = pick(rr, req, last_m[rr]);
        oh = '0; oh[w] = 1'b1;
        wd = (term == 3) || (dly + 1 > TO);
        end_c = wd ? TO : dly + 1;
        @(negedge clk);
        n_vec++;
        if ({o_grant, o_cyc} !== '0) begin
            n_err++;
            $display("FAIL idle_before_grant: grant=%b s_cyc=%b, required 0/0", o_grant, o_cyc);
        end
        @(posedge clk); #1;
        for (int c = 1; c <= end_c; c++) begin
            s_dat_r = DW'($urandom); s_ack = 1'b0; s_rty = 1'b0;
            if (c == end_c && !wd) begin
                case (term)
                    0: s_ack = 1'b1;
                    1: s_rty = 1'b1;
                    2: begin s_ack = 1'b1; s_rty = 1'b1; end
                    4: begin m_cyc[w] = 1'b0; m_stb[w] = 1'b0; end
                    default: ;
                endcase
            end
            exp_cyc = !(c == end_c && (wd || term == 4));
            exp_ack = (c == end_c && !wd && (term == 0 || term == 2)) ? oh : '0;
            exp_rty = (c == end_c && (wd || term == 1)) ? oh : '0;
            exp_to  = (c == end_c) && wd;
            @(negedge clk);
            n_vec++;
            if ({o_grant, o_cyc, o_stb, o_ack, o_rty, o_to} !== {oh, exp_cyc, exp_cyc, exp_ack, exp_rty, exp_to}) begin
                n_err++;
                $display("FAIL busy_ctrl rr=%0d cyc#%0d: grant=%b s_cyc=%b s_stb=%b ack=%b rty=%b to=%b, required %b %b %b %b %b %b",
                         rr, c, o_grant, o_cyc, o_stb, o_ack, o_rty, o_to, oh, exp_cyc, exp_cyc, exp_ack, exp_rty, exp_to);
            end
            n_vec++;
            if ({o_adr, o_we, o_dat_w, o_sel, o_dat_r} !==
                {m_adr[w*AW +: AW], m_we[w], m_dat_w[w*DW +: DW], m_sel[w*SW +: SW], s_dat_r}) begin
                n_err++;
                $display("FAIL busy_data rr=%0d cyc#%0d: adr=%h we=%b dw=%h sel=%h dr=%h, required %h %b %h %h %h",
                         rr, c, o_adr, o_we, o_dat_w, o_sel, o_dat_r, m_adr[w*AW +: AW], m_we[w],
                         m_dat_w[w*DW +: DW], m_sel[w*SW +: SW], s_dat_r);
            end
            @(posedge clk); #1;
        end
        if (!wd && term != 4) last_m[rr] = w;
        // Stray terminates during the gap cycle must not reach any master.
        s_ack = 1'b1; s_rty = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({o_grant, o_cyc, o_stb, o_ack, o_rty, o_to} !== '0) begin
            n_err++;
            $display("FAIL release_gap rr=%0d: grant=%b s_cyc=%b ack=%b rty=%b to=%b, required all 0",
                     rr, o_grant, o_cyc, o_ack, o_rty, o_to);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_single_fixed();
        txn(1'b0, 3'b001, 3, 0);
    endtask

    task automatic test_contention_fixed();
        for (int i = 0; i < 4; i++) txn(1'b0, 3'b011, $urandom_range(0, 5), 0);
    endtask

    task automatic test_contention_rr();
        for (int i = 0; i < 4; i++) txn(1'b1, 3'b011, $urandom_range(0, 5), 0);
    endtask

    task automatic test_watchdog();
        txn(1'b0, 3'b010, 0, 3);
        txn(1'b1, 3'b100, 20, 0);
    endtask

    task automatic test_simultaneous();
        txn(1'b0, 3'b001, TO - 1, 2);
        txn(1'b1, 3'b110, 1, 2);
    endtask

    task automatic test_abort_reset();
        txn(1'b0, 3'b001, 2, 4);
        rr_sel = 1'b0;
        m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b001; m_adr = '1; m_sel = '1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_ack = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({fx_grant, fx_cyc, fx_stb, fx_we, fx_adr, fx_dat_w, fx_sel, fx_ack, fx_rty, fx_to} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_busy: grant=%b s_cyc=%b we=%b adr=%h sel=%h ack=%b rty=%b to=%b, required all 0",
                     fx_grant, fx_cyc, fx_we, fx_adr, fx_sel, fx_ack, fx_rty, fx_to);
        end
        test_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom_range(0, 1)), N'($urandom_range(1, 7)), $urandom_range(0, 10), $urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_single_fixed();
        test_contention_fixed();
        test_contention_rr();
        test_watchdog();
        test_simultaneous();
        test_abort_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
